// File: rtl/nvme_defines.sv
// nvme_defines: shared widths, limits and command id layout for the NVMe command path
package nvme_defines;
  localparam int CMD_ACTION_ID_BITS = 4;
  localparam int NUM_ACT            = 2 ** CMD_ACTION_ID_BITS;
  localparam int REQ_ID_BITS        = 8;
  localparam int TRACK_NUM          = 16;
  localparam int IO_SQ_NUM          = 2;
  localparam int CMD_QUEUE_ID_BITS  = 4;
  localparam int CNT_BITS           = $clog2(TRACK_NUM + 1);
  typedef struct packed {
    logic [REQ_ID_BITS-1:0]        req_id;
    logic [CMD_ACTION_ID_BITS-1:0] action_id;
    logic [CMD_QUEUE_ID_BITS-1:0]  sq_id;
  } cmd_id_t;
  typedef enum logic [1:0] {WAIT_INIT, ARB, ISSUE} state_t;
endpackage

// File: rtl/nvme_cmd_tag_sched_if.sv
// nvme_cmd_tag_sched_if: command tag handshake between the scheduler and the SQ writer
interface nvme_cmd_tag_sched_if;
  import nvme_defines::*;
  logic                          cmd_valid;
  logic                          cmd_ready;
  cmd_id_t                       cmd_id;
  logic [CMD_ACTION_ID_BITS-1:0] cmd_action_id;
  logic [REQ_ID_BITS-1:0]        cmd_req_id;
  modport master (output cmd_valid, cmd_id, cmd_action_id, cmd_req_id, input cmd_ready);
  modport slave  (input cmd_valid, cmd_id, cmd_action_id, cmd_req_id, output cmd_ready);
endinterface

// File: rtl/nvme_rr_arbiter.sv
// nvme_rr_arbiter: picks the first request at or after ptr, searching modulo N
module nvme_rr_arbiter #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  int j;
  // rotate the search start to ptr; the first hit wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = W'(j);
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/nvme_cmd_tag_sched.sv
// nvme_cmd_tag_sched: round-robin admission of per-action commands with unique {req_id, action, sq} tags
module nvme_cmd_tag_sched
  import nvme_defines::*;
(
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic                          track_init,
  input  logic [NUM_ACT-1:0]            req_valid,
  input  logic [NUM_ACT-1:0]            req_ssd,
  output logic [NUM_ACT-1:0]            req_ack,
  nvme_cmd_tag_sched_if.master          cmd,
  input  logic                          rel_valid,
  input  logic [CMD_ACTION_ID_BITS-1:0] rel_action_id,
  output logic [NUM_ACT*CNT_BITS-1:0]   outstanding,
  output logic                          sched_error,
  input  logic                          sched_err_clr
);
  state_t                        state, state_nx;
  logic [REQ_ID_BITS-1:0]        seq [NUM_ACT];
  logic [CNT_BITS-1:0]           cnt [NUM_ACT];
  logic [CMD_QUEUE_ID_BITS-1:0]  sq_rot [2];
  logic [CMD_ACTION_ID_BITS-1:0] rr_ptr, gnt_idx;
  logic [NUM_ACT-1:0]            eligible, gnt, rel_vec;
  logic [CMD_QUEUE_ID_BITS-1:0]  sq_sel;
  logic                          gnt_any, gnt_ssd, cmd_ssd, accept, grant;
  cmd_id_t                       cmd_q;

  nvme_rr_arbiter #(.N(NUM_ACT)) u_arb (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  genvar g;
  for (g = 0; g < NUM_ACT; g++) begin : g_act
    assign eligible[g] = req_valid[g] && cnt[g] < CNT_BITS'(TRACK_NUM);
    assign outstanding[g*CNT_BITS +: CNT_BITS] = cnt[g];
  end

  assign gnt_ssd           = |(req_ssd & gnt);
  assign sq_sel            = CMD_QUEUE_ID_BITS'(gnt_ssd ? IO_SQ_NUM + 2 : 1) + sq_rot[gnt_ssd];
  assign grant             = state == ARB && gnt_any;
  assign accept            = state == ISSUE && cmd.cmd_ready;
  assign req_ack           = accept ? NUM_ACT'(1) << cmd_q.action_id : '0;
  assign rel_vec           = rel_valid ? NUM_ACT'(1) << rel_action_id : '0;
  assign cmd.cmd_valid     = state == ISSUE;
  assign cmd.cmd_id        = cmd_q;
  assign cmd.cmd_action_id = cmd_q.action_id;
  assign cmd.cmd_req_id    = cmd_q.req_id;

  // state register
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) state <= WAIT_INIT;
    else state <= state_nx;

  // wait for tracking init, arbitrate, then hold the command until accepted
  always_comb begin
    state_nx = state;
    state_nx = state == WAIT_INIT ? (track_init ? ARB : WAIT_INIT) :
               state == ARB       ? (gnt_any ? ISSUE : ARB) :
                                    (cmd.cmd_ready ? ARB : ISSUE);
  end

  // capture the tag at grant; it stays frozen through ISSUE
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      cmd_q   <= '0;
      cmd_ssd <= 1'b0;
    end else if (grant) begin
      cmd_q   <= '{req_id: seq[gnt_idx], action_id: gnt_idx, sq_id: sq_sel};
      cmd_ssd <= gnt_ssd;
    end

  // per-action sequence/outstanding bookkeeping plus SQ and round-robin rotors
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      for (int a = 0; a < NUM_ACT; a++) begin
        seq[a] <= '0;
        cnt[a] <= '0;
      end
      sq_rot[0] <= '0;
      sq_rot[1] <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int a = 0; a < NUM_ACT; a++) begin
        cnt[a] <= cnt[a] + CNT_BITS'(req_ack[a]) - CNT_BITS'(rel_vec[a] && cnt[a] != '0);
        if (req_ack[a]) seq[a] <= seq[a] == REQ_ID_BITS'(TRACK_NUM - 1) ? '0 : seq[a] + 1'b1;
      end
      if (accept) begin
        sq_rot[cmd_ssd] <= sq_rot[cmd_ssd] == CMD_QUEUE_ID_BITS'(IO_SQ_NUM - 1) ? '0 : sq_rot[cmd_ssd] + 1'b1;
        rr_ptr          <= cmd_q.action_id + 1'b1;
      end
    end

  // a release with nothing outstanding is sticky; a same-cycle set beats clear
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) sched_error <= 1'b0;
    else sched_error <= (rel_valid && cnt[rel_action_id] == '0) ? 1'b1 : sched_err_clr ? 1'b0 : sched_error;
endmodule

// File: tb/tb_nvme_cmd_tag_sched.sv
// tb_nvme_cmd_tag_sched: directed vectors and corner-case sequences for the command tag scheduler
module tb_nvme_cmd_tag_sched;
  import nvme_defines::*;

  logic                          axi_aclk = 1'b0;
  logic                          axi_aresetn;
  logic                          track_init;
  logic [NUM_ACT-1:0]            req_valid, req_ssd, req_ack;
  logic                          rel_valid;
  logic [CMD_ACTION_ID_BITS-1:0] rel_action_id;
  logic [NUM_ACT*CNT_BITS-1:0]   outstanding;
  logic                          sched_error, sched_err_clr;
  int                            checks = 0;
  int                            errors = 0;

  typedef struct {
    logic [15:0] rv;
    logic [15:0] ssd;
    logic [15:0] exp_id;
    logic [3:0]  exp_act;
    logic [15:0] exp_ack;
  } vec_t;
  vec_t tv [4];

  nvme_cmd_tag_sched_if cif ();

  nvme_cmd_tag_sched dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .track_init    (track_init),
    .req_valid     (req_valid),
    .req_ssd       (req_ssd),
    .req_ack       (req_ack),
    .cmd           (cif),
    .rel_valid     (rel_valid),
    .rel_action_id (rel_action_id),
    .outstanding   (outstanding),
    .sched_error   (sched_error),
    .sched_err_clr (sched_err_clr)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [CNT_BITS-1:0] ocnt(input int a);
    return outstanding[a*CNT_BITS +: CNT_BITS];
  endfunction

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!cif.cmd_valid && n < budget) begin
      tick();
      n++;
    end
    chk("wait_cmd_valid", 128'(cif.cmd_valid), 128'(1));
  endtask

  initial begin
    int issued;
    logic seen;
    logic [15:0] e;
    tv[0] = '{rv: 16'h0003, ssd: 16'h0003, exp_id: 16'h0104, exp_act: 4'd0, exp_ack: 16'h0001};
    tv[1] = '{rv: 16'h0003, ssd: 16'h0003, exp_id: 16'h0015, exp_act: 4'd1, exp_ack: 16'h0002};
    tv[2] = '{rv: 16'h0003, ssd: 16'h0003, exp_id: 16'h0204, exp_act: 4'd0, exp_ack: 16'h0001};
    tv[3] = '{rv: 16'h0003, ssd: 16'h0003, exp_id: 16'h0115, exp_act: 4'd1, exp_ack: 16'h0002};
    axi_aresetn = 1'b0; track_init = 1'b0; req_valid = '0; req_ssd = '0;
    cif.cmd_ready = 1'b0; rel_valid = 1'b0; rel_action_id = '0; sched_err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_valid", 128'(cif.cmd_valid), 128'(0));
    chk("rst_cmd_id", 128'(cif.cmd_id), 128'(0));
    chk("rst_req_ack", 128'(req_ack), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk("rst_sched_error", 128'(sched_error), 128'(0));
    axi_aresetn = 1'b1;
    // no grants while tracking memory is not initialised
    req_valid = 16'h0001;
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (cif.cmd_valid) seen = 1'b1;
    end
    chk("no_grant_before_init", 128'(seen), 128'(0));
    track_init = 1'b1;
    wait_valid(10);
    chk("first_cmd_id", 128'(cif.cmd_id), 128'(16'h0001));
    chk("first_cmd_req_id", 128'(cif.cmd_req_id), 128'(0));
    cif.cmd_ready = 1'b1;
    #1;
    chk("first_req_ack", 128'(req_ack), 128'(16'h0001));
    req_valid = '0;
    tick();
    cif.cmd_ready = 1'b0;
    chk("first_outstanding", 128'(ocnt(0)), 128'(1));
    chk("first_valid_drop", 128'(cif.cmd_valid), 128'(0));
    rel_valid = 1'b1; rel_action_id = 4'd0;
    tick();
    rel_valid = 1'b0;
    chk("first_release", 128'(ocnt(0)), 128'(0));
    // action 3 fills its 16 tracking slots; the 17th request blocks
    req_ssd = '0; req_valid = 16'h0008; cif.cmd_ready = 1'b1;
    issued = 0;
    repeat (40) begin
      if (cif.cmd_valid) begin
        e = {8'(issued), 4'h3, 4'((issued % 2 == 0) ? 2 : 1)};
        chk("fill_cmd_id", 128'(cif.cmd_id), 128'(e));
        chk("fill_req_ack", 128'(req_ack), 128'(16'h0008));
        issued++;
      end
      tick();
    end
    chk("fill_issued", 128'(issued), 128'(16));
    chk("fill_outstanding", 128'(ocnt(3)), 128'(16));
    chk("fill_blocked", 128'(cif.cmd_valid), 128'(0));
    rel_valid = 1'b1; rel_action_id = 4'd3;
    tick();
    rel_valid = 1'b0;
    chk("fill_release", 128'(ocnt(3)), 128'(15));
    wait_valid(10);
    chk("wrap_cmd_id", 128'(cif.cmd_id), 128'(16'h0032));
    chk("wrap_req_ack", 128'(req_ack), 128'(16'h0008));
    req_valid = '0;
    tick();
    chk("wrap_outstanding", 128'(ocnt(3)), 128'(16));
    // round robin between actions 0 and 1 on SSD1
    for (int i = 0; i < 4; i++) begin
      req_valid = tv[i].rv; req_ssd = tv[i].ssd; cif.cmd_ready = 1'b1;
      wait_valid(10);
      chk("rr_cmd_id", 128'(cif.cmd_id), 128'(tv[i].exp_id));
      chk("rr_action", 128'(cif.cmd_action_id), 128'(tv[i].exp_act));
      chk("rr_req_ack", 128'(req_ack), 128'(tv[i].exp_ack));
      if (i == 3) req_valid = '0;
      tick();
    end
    chk("rr_outstanding0", 128'(ocnt(0)), 128'(2));
    chk("rr_outstanding1", 128'(ocnt(1)), 128'(2));
    // backpressure hold, then release and accept on action 2 together
    req_ssd = '0; req_valid = 16'h0004;
    wait_valid(10);
    chk("act2_cmd_id", 128'(cif.cmd_id), 128'(16'h0021));
    req_valid = '0;
    tick();
    cif.cmd_ready = 1'b0; req_valid = 16'h0004;
    wait_valid(10);
    chk("hold_first_id", 128'(cif.cmd_id), 128'(16'h0122));
    repeat (10) begin
      tick();
      chk("hold_cmd_id", 128'(cif.cmd_id), 128'(16'h0122));
      chk("hold_no_ack", 128'(req_ack), 128'(0));
    end
    cif.cmd_ready = 1'b1; rel_valid = 1'b1; rel_action_id = 4'd2; req_valid = '0;
    #1;
    chk("same_cycle_ack", 128'(req_ack), 128'(16'h0004));
    tick();
    rel_valid = 1'b0; cif.cmd_ready = 1'b0;
    chk("same_cycle_count", 128'(ocnt(2)), 128'(1));
    chk("same_cycle_no_err", 128'(sched_error), 128'(0));
    // release underflow is sticky until cleared
    rel_valid = 1'b1; rel_action_id = 4'd5;
    tick();
    rel_valid = 1'b0;
    chk("underflow_err", 128'(sched_error), 128'(1));
    chk("underflow_count", 128'(ocnt(5)), 128'(0));
    tick();
    chk("underflow_sticky", 128'(sched_error), 128'(1));
    sched_err_clr = 1'b1;
    tick();
    sched_err_clr = 1'b0;
    chk("err_clear", 128'(sched_error), 128'(0));
    // asynchronous reset while a command is pending
    req_valid = 16'h0001; req_ssd = '0;
    wait_valid(10);
    axi_aresetn = 1'b0;
    #1;
    chk("async_rst_valid", 128'(cif.cmd_valid), 128'(0));
    repeat (2) tick();
    axi_aresetn = 1'b1;
    chk("post_rst_outstanding", 128'(outstanding), 128'(0));
    chk("post_rst_cmd_id", 128'(cif.cmd_id), 128'(0));
    cif.cmd_ready = 1'b1;
    wait_valid(10);
    chk("post_rst_regrant", 128'(cif.cmd_id), 128'(16'h0001));
    req_valid = '0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
